// File: rtl/fmps_packet_framer.sv
// FMPS packet framer: turns accepted packet requests into a two-word
// AXI-stream packet (header then data), rate-limited per fast-acquisition cycle.
module fmps_packet_framer #(
   parameter int          INDEX_WIDTH  = 5,
   parameter logic [15:0] HEADER_MAGIC = 16'hB6CF,
   parameter logic [15:0] DATA_MAGIC   = 16'hCACA
) (
   input  logic                   auClk,
   input  logic                   auReset,
   input  logic                   auChannelUp,
   input  logic                   auFAstrobe,
   input  logic                   genPacketStrobe,
   input  logic [INDEX_WIDTH-1:0] baseIndex,
   input  logic [INDEX_WIDTH:0]   pktsPerCycle,
   output logic [31:0]            auFMPSlinkTDATA,
   output logic                   auFMPSlinkTVALID,
   output logic                   auFMPSlinkTLAST,
   input  logic                   auFMPSlinkTREADY,
   output logic [15:0]            dropCount,
   output logic                   busy
);

   localparam int CNT_W = INDEX_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;
   logic [15:0]            drop_cnt_q, drop_cnt_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [INDEX_WIDTH-1:0] pend_index_q, pend_index_d;
   logic [7:0]             pend_cycle_q, pend_cycle_d;
   logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
   logic [7:0]             out_cycle_q, out_cycle_d;

   logic [CNT_W-1:0]       fa_pkt_cnt;
   logic [7:0]             fa_cycle;
   logic                   accept;
   logic                   start_ok;
   logic [4:0]             idx_field;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      // The FA update is applied before the request is judged, so a
      // coincident strobe sees a cleared packet count and the new cycle.
      fa_pkt_cnt   = auFAstrobe ? '0 : pkt_cnt_q;
      fa_cycle     = cycle_cnt_q + 8'(auFAstrobe);
      accept       = genPacketStrobe && auChannelUp && !pend_valid_q &&
                     (fa_pkt_cnt < pktsPerCycle);
      start_ok     = pend_valid_q && auChannelUp;

      cycle_cnt_d  = fa_cycle;
      pkt_cnt_d    = fa_pkt_cnt + CNT_W'(accept);
      drop_cnt_d   = drop_cnt_q;
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_index_d = pend_index_q;
      pend_cycle_d = pend_cycle_q;
      out_index_d  = out_index_q;
      out_cycle_d  = out_cycle_q;

      if (genPacketStrobe && !accept && (drop_cnt_q != 16'hFFFF))
         drop_cnt_d = drop_cnt_q + 16'd1;

      // An unstarted request dies silently if the link goes down.
      if (pend_valid_q && !auChannelUp)
         pend_valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               out_index_d  = pend_index_q;
               out_cycle_d  = pend_cycle_q;
               pend_valid_d = 1'b0;
               state_d      = HEADER;
            end
         end
         HEADER: begin
            if (auFMPSlinkTREADY)
               state_d = DATA;
         end
         DATA: begin
            if (auFMPSlinkTREADY) begin
               if (start_ok) begin
                  out_index_d  = pend_index_q;
                  out_cycle_d  = pend_cycle_q;
                  pend_valid_d = 1'b0;
                  state_d      = HEADER;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Acceptance needs an empty slot, so it never collides with the unload above.
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_index_d = baseIndex + fa_pkt_cnt[INDEX_WIDTH-1:0];
         pend_cycle_d = fa_cycle;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge auClk or posedge auReset) begin
      if (auReset) begin
         state_q      <= IDLE;
         cycle_cnt_q  <= '0;
         pkt_cnt_q    <= '0;
         drop_cnt_q   <= '0;
         pend_valid_q <= 1'b0;
         pend_index_q <= '0;
         pend_cycle_q <= '0;
         out_index_q  <= '0;
         out_cycle_q  <= '0;
      end else begin
         state_q      <= state_d;
         cycle_cnt_q  <= cycle_cnt_d;
         pkt_cnt_q    <= pkt_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_index_q <= pend_index_d;
         pend_cycle_q <= pend_cycle_d;
         out_index_q  <= out_index_d;
         out_cycle_q  <= out_cycle_d;
      end
   end

   always_comb begin
      idx_field        = 5'(out_index_q);
      auFMPSlinkTDATA  = 32'd0;
      auFMPSlinkTVALID = 1'b0;
      auFMPSlinkTLAST  = 1'b0;
      unique case (state_q)
         HEADER: begin
            auFMPSlinkTVALID = 1'b1;
            auFMPSlinkTDATA  = {HEADER_MAGIC, 1'b0, idx_field, 10'd0};
         end
         DATA: begin
            auFMPSlinkTVALID = 1'b1;
            auFMPSlinkTLAST  = 1'b1;
            auFMPSlinkTDATA  = {3'd0, idx_field, DATA_MAGIC, out_cycle_q};
         end
         default: ;
      endcase
   end

   assign dropCount = drop_cnt_q;
   assign busy      = (state_q != IDLE) || pend_valid_q;

endmodule

// File: tb/tb_fmps_packet_framer.sv
// Self-checking bench for fmps_packet_framer: a transaction-level model
// predicts the word stream and drop count from the request rules.
module tb_fmps_packet_framer;

   localparam int          IW = 5;
   localparam logic [15:0] HM = 16'hB6CF;
   localparam logic [15:0] DM = 16'hCACA;

   logic          auClk;
   logic          auReset;
   logic          auChannelUp;
   logic          auFAstrobe;
   logic          genPacketStrobe;
   logic [IW-1:0] baseIndex;
   logic [IW:0]   pktsPerCycle;
   logic [31:0]   auFMPSlinkTDATA;
   logic          auFMPSlinkTVALID;
   logic          auFMPSlinkTLAST;
   logic          auFMPSlinkTREADY;
   logic [15:0]   dropCount;
   logic          busy;

   fmps_packet_framer #(
      .INDEX_WIDTH (IW),
      .HEADER_MAGIC(HM),
      .DATA_MAGIC  (DM)
   ) dut (
      .auClk           (auClk),
      .auReset         (auReset),
      .auChannelUp     (auChannelUp),
      .auFAstrobe      (auFAstrobe),
      .genPacketStrobe (genPacketStrobe),
      .baseIndex       (baseIndex),
      .pktsPerCycle    (pktsPerCycle),
      .auFMPSlinkTDATA (auFMPSlinkTDATA),
      .auFMPSlinkTVALID(auFMPSlinkTVALID),
      .auFMPSlinkTLAST (auFMPSlinkTLAST),
      .auFMPSlinkTREADY(auFMPSlinkTREADY),
      .dropCount       (dropCount),
      .busy            (busy)
   );

   initial auClk = 1'b0;
   always #5 auClk = ~auClk;

   typedef struct {
      logic        last;
      logic [31:0] data;
   } beat_t;

   int    errors = 0;
   int    checks = 0;
   beat_t exp_q[$];
   int    m_cycle, m_pkt, m_drop;

   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = '0;
   logic        prev_last  = 1'b0;

   function automatic logic [31:0] hdr_word(int idx);
      logic [4:0] i5;
      i5 = idx[4:0];
      return {HM, 1'b0, i5, 10'd0};
   endfunction

   function automatic logic [31:0] dat_word(int idx, int cyc);
      logic [4:0] i5;
      logic [7:0] c8;
      i5 = idx[4:0];
      c8 = cyc[7:0];
      return {3'd0, i5, DM, c8};
   endfunction

   // Stream scoreboard, sampled mid-cycle on the falling edge.
   task automatic monitor_sample();
      beat_t b;
      if (auReset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (auFMPSlinkTVALID !== 1'b1 || auFMPSlinkTDATA !== prev_data ||
                auFMPSlinkTLAST !== prev_last) begin
               errors++;
               $display("FAIL hold_stable: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                        auFMPSlinkTVALID, auFMPSlinkTDATA, auFMPSlinkTLAST, prev_data, prev_last);
            end
         end
         if (auFMPSlinkTVALID && auFMPSlinkTREADY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got data=%h last=%b, need no word",
                        auFMPSlinkTDATA, auFMPSlinkTLAST);
            end else begin
               b = exp_q.pop_front();
               if (auFMPSlinkTDATA !== b.data || auFMPSlinkTLAST !== b.last) begin
                  errors++;
                  $display("FAIL stream_word: got data=%h last=%b, need data=%h last=%b",
                           auFMPSlinkTDATA, auFMPSlinkTLAST, b.data, b.last);
               end
            end
         end
         prev_stall = auFMPSlinkTVALID && !auFMPSlinkTREADY;
         prev_data  = auFMPSlinkTDATA;
         prev_last  = auFMPSlinkTLAST;
      end
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step();
      @(negedge auClk);
      monitor_sample();
      @(posedge auClk);
      #1;
   endtask

   task automatic model_reset();
      m_cycle = 0;
      m_pkt   = 0;
      m_drop  = 0;
      exp_q.delete();
   endtask

   // Request rules: FA first, then accept if link up, under the per-cycle
   // quota and the one-deep slot is free; otherwise count a drop.
   task automatic model_req(input bit fa, input bit gs, input bit slot_free);
      int    idx;
      beat_t b;
      if (fa) begin
         m_cycle = (m_cycle + 1) % 256;
         m_pkt   = 0;
      end
      if (gs) begin
         if (auChannelUp && (m_pkt < int'(pktsPerCycle)) && slot_free) begin
            idx    = (int'(baseIndex) + m_pkt) % (1 << IW);
            b.last = 1'b0; b.data = hdr_word(idx);         exp_q.push_back(b);
            b.last = 1'b1; b.data = dat_word(idx, m_cycle); exp_q.push_back(b);
            m_pkt++;
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end
   endtask

   task automatic cycle_drive(input bit fa, input bit gs, input bit slot_free);
      auFAstrobe      = fa;
      genPacketStrobe = gs;
      model_req(fa, gs, slot_free);
      step();
      auFAstrobe      = 1'b0;
      genPacketStrobe = 1'b0;
   endtask

   task automatic drain(input int max_cycles, input bit rand_ready, output int n);
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         if (rand_ready) auFMPSlinkTREADY = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d words outstanding after %0d cycles, need 0",
                  exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      auReset = 1'b1; auChannelUp = 1'b0; auFAstrobe = 1'b0; genPacketStrobe = 1'b0;
      baseIndex = '0; pktsPerCycle = '0; auFMPSlinkTREADY = 1'b0;
      #1;
      step();
      step();
      checks++;
      if ({auFMPSlinkTVALID, auFMPSlinkTLAST, auFMPSlinkTDATA, busy, dropCount} !== 50'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b last=%b data=%h busy=%b drop=%0d, need all 0",
                  auFMPSlinkTVALID, auFMPSlinkTLAST, auFMPSlinkTDATA, busy, dropCount);
      end
      auReset = 1'b0;
      model_reset();
      step();
   endtask

   task automatic test_basic();
      int n;
      auChannelUp = 1'b1; baseIndex = 5'd8; pktsPerCycle = 6'd2; auFMPSlinkTREADY = 1'b1;
      cycle_drive(0, 1, 1);
      step();
      checks++;
      if (auFMPSlinkTVALID !== 1'b1 || auFMPSlinkTDATA !== 32'hB6CF2000 || auFMPSlinkTLAST !== 1'b0) begin
         errors++;
         $display("FAIL basic_header: got valid=%b data=%h last=%b, need 1 b6cf2000 0",
                  auFMPSlinkTVALID, auFMPSlinkTDATA, auFMPSlinkTLAST);
      end
      step();
      checks++;
      if (auFMPSlinkTVALID !== 1'b1 || auFMPSlinkTDATA !== 32'h08CACA00 || auFMPSlinkTLAST !== 1'b1) begin
         errors++;
         $display("FAIL basic_data: got valid=%b data=%h last=%b, need 1 08caca00 1",
                  auFMPSlinkTVALID, auFMPSlinkTDATA, auFMPSlinkTLAST);
      end
      drain(20, 0, n);
      step();
      checks++;
      if (busy !== 1'b0 || auFMPSlinkTVALID !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: got busy=%b valid=%b, need 0 0", busy, auFMPSlinkTVALID);
      end
   endtask

   task automatic test_fa_limit();
      int n;
      auChannelUp = 1'b1; baseIndex = 5'd8; pktsPerCycle = 6'd2; auFMPSlinkTREADY = 1'b1;
      cycle_drive(1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         repeat (15) step();
         cycle_drive(0, 1, 1);
      end
      drain(40, 0, n);
      checks++;
      if (dropCount !== 16'(m_drop)) begin
         errors++;
         $display("FAIL fa_limit_drop: got %0d, need %0d", dropCount, m_drop);
      end
   endtask

   task automatic test_random();
      int n;
      auFMPSlinkTREADY = 1'b0;
      for (int it = 0; it < 80; it++) begin
         drain(200, 1, n);
         baseIndex        = 5'($urandom_range(0, 31));
         pktsPerCycle     = 6'($urandom_range(0, 3));
         auChannelUp      = ($urandom_range(0, 7) != 0);
         auFMPSlinkTREADY = 1'($urandom_range(0, 1));
         cycle_drive(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1);
      end
      drain(200, 1, n);
      auFMPSlinkTREADY = 1'b1;
      step();
      step();
      checks++;
      if (dropCount !== 16'(m_drop) || busy !== 1'b0) begin
         errors++;
         $display("FAIL random_end: got drop=%0d busy=%b, need drop=%0d busy=0",
                  dropCount, busy, m_drop);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      auChannelUp = 1'b1; pktsPerCycle = 6'd16; baseIndex = 5'($urandom_range(0, 31));
      auFMPSlinkTREADY = 1'b1;
      cycle_drive(1, 0, 1);
      auFMPSlinkTREADY = 1'b0;
      cycle_drive(0, 1, 1);
      step();
      checks++;
      if (auFMPSlinkTVALID !== 1'b1) begin
         errors++;
         $display("FAIL b2b_latency: got valid=%b, need 1", auFMPSlinkTVALID);
      end
      cycle_drive(0, 1, 1);
      cycle_drive(0, 1, 0);
      checks++;
      if (dropCount !== 16'(m_drop) || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pending: got drop=%0d busy=%b, need drop=%0d busy=1",
                  dropCount, busy, m_drop);
      end
      auFMPSlinkTREADY = 1'b1;
      drain(20, 0, n);
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL b2b_cycles: got %0d cycles for two packets, need 4", n);
      end
   endtask

   task automatic test_channel_down();
      int    n;
      beat_t b;
      auChannelUp = 1'b1; pktsPerCycle = 6'd16; baseIndex = 5'd3; auFMPSlinkTREADY = 1'b1;
      cycle_drive(1, 0, 1);
      auFMPSlinkTREADY = 1'b0;
      cycle_drive(0, 1, 1);
      step();
      auChannelUp = 1'b0;
      cycle_drive(0, 1, 1);
      cycle_drive(0, 1, 1);
      auFMPSlinkTREADY = 1'b1;
      drain(20, 0, n);
      step();
      checks++;
      if (dropCount !== 16'(m_drop) || busy !== 1'b0) begin
         errors++;
         $display("FAIL chdown_inflight: got drop=%0d busy=%b, need drop=%0d busy=0",
                  dropCount, busy, m_drop);
      end
      // A request still waiting in the slot when the link drops is discarded.
      auChannelUp = 1'b1; auFMPSlinkTREADY = 1'b0;
      cycle_drive(0, 1, 1);
      step();
      cycle_drive(0, 1, 1);
      auChannelUp = 1'b0;
      step();
      b = exp_q.pop_back();
      b = exp_q.pop_back();
      auFMPSlinkTREADY = 1'b1;
      drain(20, 0, n);
      auChannelUp = 1'b1;
      repeat (3) step();
      checks++;
      if (dropCount !== 16'(m_drop) || busy !== 1'b0 || auFMPSlinkTVALID !== 1'b0) begin
         errors++;
         $display("FAIL chdown_discard: got drop=%0d busy=%b valid=%b, need drop=%0d busy=0 valid=0",
                  dropCount, busy, auFMPSlinkTVALID, m_drop);
      end
   endtask

   task automatic test_fa_coincide();
      int n;
      auChannelUp = 1'b1; pktsPerCycle = 6'd4; baseIndex = 5'($urandom_range(0, 31));
      auFMPSlinkTREADY = 1'b1;
      cycle_drive(0, 1, 1);
      drain(20, 0, n);
      cycle_drive(1, 1, 1);
      drain(20, 0, n);
      for (int i = 0; i < 256; i++) cycle_drive(1, 0, 1);
      cycle_drive(0, 1, 1);
      drain(20, 0, n);
      while (m_cycle != 255) cycle_drive(1, 0, 1);
      cycle_drive(0, 1, 1);
      drain(20, 0, n);
      cycle_drive(1, 1, 1);
      step();
      step();
      checks++;
      if (auFMPSlinkTDATA[7:0] !== 8'h00 || auFMPSlinkTDATA[28:24] !== baseIndex ||
          auFMPSlinkTLAST !== 1'b1) begin
         errors++;
         $display("FAIL fa_wrap: got cycle=%h index=%h last=%b, need cycle=00 index=%h last=1",
                  auFMPSlinkTDATA[7:0], auFMPSlinkTDATA[28:24], auFMPSlinkTLAST, baseIndex);
      end
      drain(20, 0, n);
   endtask

   task automatic test_reset_mid_packet();
      int n;
      auChannelUp = 1'b1; pktsPerCycle = 6'd4; baseIndex = 5'd17; auFMPSlinkTREADY = 1'b1;
      cycle_drive(1, 0, 1);
      auFMPSlinkTREADY = 1'b0;
      cycle_drive(0, 1, 1);
      step();
      auReset = 1'b1;
      #1;
      checks++;
      if (auFMPSlinkTVALID !== 1'b0 || busy !== 1'b0 || dropCount !== 16'd0) begin
         errors++;
         $display("FAIL reset_abort: got valid=%b busy=%b drop=%0d, need 0 0 0",
                  auFMPSlinkTVALID, busy, dropCount);
      end
      step();
      auReset = 1'b0;
      model_reset();
      step();
      auFMPSlinkTREADY = 1'b1;
      cycle_drive(0, 1, 1);
      drain(20, 0, n);
      step();
      checks++;
      if (dropCount !== 16'(m_drop) || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_restart: got drop=%0d busy=%b, need drop=%0d busy=0",
                  dropCount, busy, m_drop);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fa_limit();
      test_random();
      test_back_to_back();
      test_channel_down();
      test_fa_coincide();
      test_reset_mid_packet();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
